// File: rtl/sprite_pixel_packer.sv
// -----------------------------------------------------------------------------
// sprite_pixel_packer
//
// Packs a row-major stream of 4-bit palette indices for one sprite into 32-bit
// words and writes them into the sprite BRAM. Each word holds 8 pixels,
// LSB-first: pixel L lands in word L/8, bits [4*(L%8)+3 : 4*(L%8)]. This block
// is the write-side counterpart of the per-pixel nibble select done at display
// time.
//
// Ports
//   Clk        system clock, all state on the rising edge
//   Reset_n    asynchronous active-low reset
//   start      begin a sprite load (honoured only in IDLE)
//   abort      cancel the load in progress (honoured only in LOAD)
//   pix_valid  pix_data carries a valid palette index
//   pix_data   palette index of the current pixel
//   pix_ready  packer accepts a pixel this cycle (high throughout LOAD)
//   we         BRAM write enable, registered one-cycle pulse per word
//   waddr      BRAM word address, holds between writes
//   wdata      packed word, holds between writes
//   busy       high in LOAD and DONE
//   done       one-cycle pulse when the load completes
//   dbg_state  current FSM state (0 IDLE, 1 LOAD, 2 DONE)
//
// Handshake: a pixel is transferred on a rising edge where pix_valid and
// pix_ready are both high. pix_valid may be raised or dropped freely; pix_data
// is ignored whenever pix_valid is low. pix_ready does not depend on pix_valid.
// -----------------------------------------------------------------------------
module sprite_pixel_packer #(
  parameter int SPRITE_W  = 20,
  parameter int SPRITE_H  = 20,
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              pix_valid,
  input  logic [3:0]        pix_data,
  output logic              pix_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state
);

  localparam int TOTAL = SPRITE_W * SPRITE_H;
  // Counter must be able to hold TOTAL itself, not just TOTAL-1.
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(TOTAL - 1);
  localparam logic [ADDR_W-1:0] BASE_ADDRV = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [31:0]       acc_q, acc_d;
  logic [2:0]        nib_idx_q, nib_idx_d;
  logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [ADDR_W-1:0] word_addr_q, word_addr_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic        load_init;
  logic        xfer;
  logic        last_pix;
  logic        word_fire;
  logic [31:0] merged;

  // An abort in the same cycle as a valid pixel drops that pixel, so the
  // transfer is qualified with !abort.
  assign load_init = (state_q == ST_IDLE) && start;
  assign xfer      = (state_q == ST_LOAD) && pix_valid && !abort;
  assign last_pix  = (pix_cnt_q == LAST_CNT);
  assign word_fire = xfer && ((nib_idx_q == 3'd7) || last_pix);

  // Nibbles above nib_idx are always zero in the accumulator, so OR-ing the
  // new nibble in is enough; this also zero-fills a final partial word.
  assign merged = acc_q | ({28'd0, pix_data} << {nib_idx_q, 2'b00});

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        // abort wins over completion of the final pixel
        if (abort)                 state_d = ST_IDLE;
        else if (xfer && last_pix) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    pix_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        pix_ready = 1'b0;
        busy      = 1'b0;
      end
      ST_LOAD: begin
        pix_ready = 1'b1;
        busy      = 1'b1;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        pix_ready = 1'b0;
      end
    endcase
  end

  assign dbg_state = state_q;

  // ---------------------------------------------------------------------------
  // Datapath: accumulator, counters and BRAM write port
  // ---------------------------------------------------------------------------
  always_comb begin
    acc_d       = acc_q;
    nib_idx_d   = nib_idx_q;
    pix_cnt_d   = pix_cnt_q;
    word_addr_d = word_addr_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;

    if (load_init) begin
      acc_d       = 32'd0;
      nib_idx_d   = 3'd0;
      pix_cnt_d   = '0;
      word_addr_d = BASE_ADDRV;
    end else if (xfer) begin
      pix_cnt_d = pix_cnt_q + CNT_W'(1);
      if (word_fire) begin
        // Write goes out with the current nibble already included; the
        // accumulator restarts empty so there is no stall between words.
        we_d        = 1'b1;
        waddr_d     = word_addr_q;
        wdata_d     = merged;
        acc_d       = 32'd0;
        nib_idx_d   = 3'd0;
        word_addr_d = word_addr_q + ADDR_W'(1);
      end else begin
        acc_d     = merged;
        nib_idx_d = nib_idx_q + 3'd1;
      end
    end else if ((state_q == ST_LOAD) && abort) begin
      // Partial word is thrown away; nothing is written.
      acc_d     = 32'd0;
      nib_idx_d = 3'd0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      acc_q       <= 32'd0;
      nib_idx_q   <= 3'd0;
      pix_cnt_q   <= '0;
      word_addr_q <= BASE_ADDRV;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= 32'd0;
    end else begin
      acc_q       <= acc_d;
      nib_idx_q   <= nib_idx_d;
      pix_cnt_q   <= pix_cnt_d;
      word_addr_q <= word_addr_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign we    = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;

endmodule

// File: doc/sprite_pixel_packer.md
Name: sprite_pixel_packer

Overview:
- Loads sprite bitmaps into the 32-bit sprite BRAM that the sprite color mappers read.
- Accepts a stream of 4-bit palette indices, one pixel per transfer, in row-major order over a SPRITE_W x SPRITE_H sprite.
- Packs 8 indices per word, LSB-first: the pixel with linear index L lands in word L/8, nibble L%8, bits [4*(L%8)+3 : 4*(L%8)].
- Issues single-cycle BRAM writes, and is the write-side counterpart to the per-pixel nibble selection done at display time.

Parameters:
SPRITE_W, 20, sprite width in pixels
SPRITE_H, 20, sprite height in pixels
ADDR_W, 6, BRAM word-address width
BASE_ADDR, 0, first word address written for the sprite

Ports:
Clk  in  1  system clock, all state on rising edge
Reset_n  in  1  asynchronous active-low reset
start  in  1  begin a sprite load; honoured only in IDLE
abort  in  1  cancel the load in progress; return to IDLE
pix_valid  in  1  pix_data holds a valid index
pix_data  in  4  palette index of the current pixel
pix_ready  out  1  packer accepts a pixel this cycle
we  out  1  BRAM write enable, one-cycle pulse per word
waddr  out  ADDR_W  BRAM word address
wdata  out  32  packed word
busy  out  1  high in LOAD and DONE
done  out  1  one-cycle pulse on load completion

Behaviour:
- Derived constants:
  - TOTAL = SPRITE_W*SPRITE_H.
  - WORDS = ceil(TOTAL/8).
  - The pixel counter is wide enough to hold TOTAL (9 bits at default).
- Reset (async assert, sync release):
  - state=IDLE; pix_ready=0, we=0, waddr=0, wdata=0, busy=0, done=0.
  - Accumulator, nibble index and pixel counter = 0.
- States are IDLE, LOAD and DONE.
- IDLE:
  - pix_ready=0, busy=0.
  - start=1 moves to LOAD, clears the accumulator, nib_idx=0, pix_cnt=0, word_addr=BASE_ADDR.
- LOAD:
  - pix_ready=1, busy=1.
  - A transfer occurs on a rising edge with pix_valid & pix_ready.
  - On transfer: acc[nib_idx] <= pix_data; nib_idx++; pix_cnt++.
  - Word write, triggered when the transfer is the 8th nibble (nib_idx==7) or the final pixel (pix_cnt==TOTAL-1). On that same edge:
    - we<=1, waddr<=word_addr, wdata<=assembled word including the current nibble; unfilled nibbles of a final partial word are 0.
    - Accumulator cleared, nib_idx<=0, word_addr++.
  - word_addr wraps modulo 2^ADDR_W and is not checked.
  - After the final-pixel transfer, state goes to DONE.
  - No stall on a write: pix_ready stays 1 between words, so 8 consecutive transfers every 8 cycles are sustained.
- we is a registered one-cycle pulse; it deasserts on the next edge unless another write triggers. wdata and waddr hold their last values between writes.
- DONE:
  - pix_ready=0, busy=1, done=1 for exactly one cycle, then IDLE.
  - The final word's we pulse coincides with the DONE cycle.
- start:
  - Ignored in LOAD and DONE.
  - start held high through DONE begins a new load on the first IDLE cycle.
- abort (LOAD only):
  - Next state is IDLE; the partial accumulator is discarded and no write is issued.
  - done is not pulsed.
  - If abort coincides with a transfer, the transfer is dropped, including any write it would have triggered.
  - abort has priority over completion.
  - abort is ignored in IDLE and DONE.
- Asynchronous reset mid-load clears all state immediately; any pending we is cancelled.
- pix_data is don't-care when pix_valid=0. pix_valid in IDLE/DONE is ignored; nothing is consumed.

Test Plan:
- Default params, start, then 400 back-to-back pixels with pix_data=L%16:
  - 50 we pulses, waddr 0..49.
  - Even addresses wdata=0x76543210, odd addresses wdata=0xFEDCBA98.
  - done pulses once, in the same cycle as the we for addr 49; then busy=0, pix_ready=0.
- Same load with pix_valid toggled pseudo-randomly (~50% duty): identical write sequence and data; no pixel lost or duplicated.
- SPRITE_W=3, SPRITE_H=3, BASE_ADDR=10, pix_data=L:
  - writes addr10=0x76543210 and addr11=0x00000008.
  - done with the second write.
- Default params, load 13 pixels, assert abort with pix_valid=1:
  - exactly one write (addr 0).
  - 14th pixel not consumed, no done, state IDLE.
  - A fresh start then rewrites from addr 0 with nibble 0 aligned.
- start pulsed repeatedly during LOAD and during DONE: no counter/address restart, the load completes normally. start held across DONE starts a second load one cycle after done.
- Reset_n low mid-word (after 5 pixels), asynchronously between edges:
  - outputs drop to reset values before the next edge.
  - No we after release; the next load begins at BASE_ADDR, nibble 0.
